// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared opcodes, FSM states and instruction-field helpers for the CVP14 core
package cvp14_pkg;
    localparam int W = 16;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_SLD  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;
    localparam logic [W-1:0] IR_RESET = {OP_NOP, 12'h000};
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALTED} state_t;
    function automatic logic [3:0] f_op(input logic [W-1:0] i);
        return i[15:12];
    endfunction
    function automatic logic [2:0] f_rd(input logic [W-1:0] i);
        return i[11:9];
    endfunction
    function automatic logic [2:0] f_rs(input logic [W-1:0] i);
        return i[8:6];
    endfunction
    function automatic logic [2:0] f_rt(input logic [W-1:0] i);
        return i[5:3];
    endfunction
    function automatic logic [7:0] f_imm8(input logic [W-1:0] i);
        return i[7:0];
    endfunction
    function automatic logic [W-1:0] f_imm6(input logic [W-1:0] i);
        return {{10{i[5]}}, i[5:0]};
    endfunction
    function automatic logic [W-1:0] f_imm9(input logic [W-1:0] i);
        return {{7{i[8]}}, i[8:0]};
    endfunction
    function automatic logic [W-1:0] f_imm12(input logic [W-1:0] i);
        return {{4{i[11]}}, i[11:0]};
    endfunction
endpackage

// File: rtl/cvp14_alu.sv
// cvp14_alu: combinational ADD/SUB/AND with signed overflow
module cvp14_alu
    import cvp14_pkg::*;
(
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         v
);
    always_comb begin
        y = op == OP_SUB ? a - b : op == OP_AND ? a & b : a + b;
        v = (op == OP_SUB ? a[W-1] != b[W-1] : a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    end
endmodule

// File: rtl/cvp14_synth.sv
// cvp14_synth: multi-cycle 16-bit load/store core, FETCH/DECODE/EXEC/WB/HALTED
module cvp14_synth
    import cvp14_pkg::*;
#(
    parameter logic [W-1:0] RESET_PC = 16'h0000
) (
    input  logic         Clk1,
    input  logic         Reset,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] Addr,
    output logic         RD,
    output logic         WR,
    output logic [W-1:0] DataOut,
    output logic         V
);
    state_t state, next;
    logic [W-1:0] pc, ir, pc_d, rf_d, ea, rs_val, rt_val, rd_val, alu_y;
    logic [W-1:0] regs [8];
    logic [3:0] op;
    logic [2:0] rd;
    logic is_alu, rf_we, alu_v;
    always_comb begin
        op     = f_op(ir);
        rd     = f_rd(ir);
        rs_val = regs[f_rs(ir)];
        rt_val = regs[f_rt(ir)];
        rd_val = regs[rd];
        ea     = rs_val + f_imm6(ir);
        is_alu = op == OP_ADD || op == OP_SUB || op == OP_AND;
    end
    cvp14_alu alu (
        .op(op),
        .a(rs_val),
        .b(rt_val),
        .y(alu_y),
        .v(alu_v)
    );
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            FETCH:   next = DECODE;
            DECODE:  next = EXEC;
            EXEC:    next = op == OP_SLD ? WB : op == OP_HALT ? HALTED : FETCH;
            WB:      next = FETCH;
            default: next = HALTED;
        endcase
    end
    always_comb begin
        RD      = state == FETCH || (state == EXEC && op == OP_SLD);
        WR      = state == EXEC && op == OP_SST;
        Addr    = state == EXEC && (op == OP_SST || op == OP_SLD) ? ea : pc;
        DataOut = rd_val;
    end
    // PC already points past the current instruction during EXEC, so branch offsets add directly
    always_comb begin
        pc_d  = state == DECODE ? pc + 16'd1 :
                state == EXEC && op == OP_J ? pc + f_imm12(ir) :
                state == EXEC && op == OP_BZ && rd_val == '0 ? pc + f_imm9(ir) : pc;
        rf_we = state == WB || (state == EXEC && (is_alu || op == OP_SLL || op == OP_SLH));
        rf_d  = state == WB ? DataIn :
                op == OP_SLL ? {rd_val[15:8], f_imm8(ir)} :
                op == OP_SLH ? {f_imm8(ir), rd_val[7:0]} : alu_y;
    end
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            pc <= RESET_PC;
            ir <= IR_RESET;
            V  <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            pc <= pc_d;
            if (state == DECODE) ir <= DataIn;
            if (state == EXEC && (op == OP_ADD || op == OP_SUB)) V <= alu_v;
            if (rf_we) regs[rd] <= rf_d;
        end
    end
endmodule

// File: tb/tb_cvp14_synth.sv
// tb_cvp14_synth: lockstep ISA-level reference model checking the core's bus cycle by cycle
module tb_cvp14_synth;
    logic Clk1 = 1'b0;
    logic Reset = 1'b0;
    logic [15:0] DataIn = '0;
    logic [15:0] Addr, DataOut;
    logic RD, WR, V;
    logic [15:0] mem [65536];
    logic [15:0] mm [65536];
    logic [15:0] mr [8];
    logic [15:0] mpc;
    logic mv;
    int vectors = 0, errs = 0;

    always #5 Clk1 = ~Clk1;

    cvp14_synth #(.RESET_PC(16'h0000)) dut (
        .Clk1(Clk1), .Reset(Reset), .DataIn(DataIn), .Addr(Addr),
        .RD(RD), .WR(WR), .DataOut(DataOut), .V(V)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string ph, input logic [15:0] a, input logic r, input logic w);
        chk({ph, "_addr"}, Addr, a);
        chk({ph, "_rd"}, {15'd0, RD}, {15'd0, r});
        chk({ph, "_wr"}, {15'd0, WR}, {15'd0, w});
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d;
        mm[a] = d;
    endtask

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
        return {op, d, s, t, 3'b000};
    endfunction
    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d, input logic [8:0] low);
        return {op, d, low};
    endfunction

    function automatic logic [15:0] rnd_ins();
        logic [2:0] d = 3'($urandom);
        logic [2:0] s = 3'($urandom);
        logic [2:0] t = 3'($urandom);
        logic [5:0] i6 = 6'($urandom);
        logic [7:0] i8 = 8'($urandom);
        case ($urandom_range(0, 11))
            0, 11: return {4'h0, d, s, t, 3'($urandom)};
            1: return {4'h1, d, s, t, 3'($urandom)};
            2: return {4'h2, d, s, t, 3'($urandom)};
            3: return {4'h3, d, s, i6};
            4: return {4'h4, d, s, i6};
            5: return {4'h6, d, 1'($urandom), i8};
            6: return {4'h7, d, 1'($urandom), i8};
            7: return {4'h9, d, 9'($urandom_range(0, 3))};
            8: return {4'h8, 12'($urandom_range(0, 3))};
            9: return {4'hF, 12'($urandom)};
            default: return {($urandom_range(0, 1) != 0) ? 4'h5 : 4'($urandom_range(10, 13)), 12'($urandom)};
        endcase
    endfunction

    task automatic reset_start();
        Reset = 1'b0;
        #1;
        chk_bus("in_reset", 16'h0000, 1'b1, 1'b0);
        chk("in_reset_dout", DataOut, 16'h0000);
        chk("in_reset_v", {15'd0, V}, 16'd0);
        mpc = 16'h0000;
        mv = 1'b0;
        mr = '{default: '0};
    endtask

    task automatic release_reset();
        @(posedge Clk1);
        #1 Reset = 1'b1;
    endtask

    // One instruction, architecturally: fetch, decode, execute (+ writeback for loads)
    task automatic run_instr(output bit halted);
        logic [15:0] ins, ea, a, b;
        logic [3:0] op;
        logic [2:0] rd;
        int s;
        halted = 1'b0;
        @(negedge Clk1);
        chk_bus("fetch", mpc, 1'b1, 1'b0);
        chk("v", {15'd0, V}, {15'd0, mv});
        ins = mm[mpc];
        @(negedge Clk1);
        chk_bus("decode", mpc, 1'b0, 1'b0);
        mpc = mpc + 16'd1;
        op = ins[15:12];
        rd = ins[11:9];
        a = mr[ins[8:6]];
        b = mr[ins[5:3]];
        ea = 16'(int'(a) + int'($signed(ins[5:0])));
        @(negedge Clk1);
        if (op != 4'h3 && op != 4'h4) chk_bus("exec", mpc, 1'b0, 1'b0);
        case (op)
            4'h0, 4'h1: begin
                s = op == 4'h0 ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
                mr[rd] = 16'(s);
                mv = s > 32767 || s < -32768;
            end
            4'h2: mr[rd] = a & b;
            4'h3: begin
                chk_bus("sst", ea, 1'b0, 1'b1);
                chk("sst_data", DataOut, mr[rd]);
                mm[ea] = mr[rd];
            end
            4'h4: begin
                chk_bus("sld", ea, 1'b1, 1'b0);
                @(negedge Clk1);
                chk_bus("wb", mpc, 1'b0, 1'b0);
                mr[rd] = mm[ea];
            end
            4'h6: mr[rd][7:0] = ins[7:0];
            4'h7: mr[rd][15:8] = ins[7:0];
            4'h8: mpc = 16'(int'(mpc) + int'($signed(ins[11:0])));
            4'h9: if (mr[rd] == 16'h0000) mpc = 16'(int'(mpc) + int'($signed(ins[8:0])));
            4'hE: halted = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_prog(input int budget, output bit halted);
        int n = 0;
        halted = 1'b0;
        while (!halted && n < budget) begin
            run_instr(halted);
            n++;
        end
        if (halted) repeat (10) begin
            @(negedge Clk1);
            chk_bus("halted", mpc, 1'b0, 1'b0);
        end
    endtask

    task automatic dump_chk();
        int bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) bad++;
        chk("dump_bad_words", 16'(bad), 16'd0);
    endtask

    initial begin
        bit h;
        fork
            forever begin
                @(posedge Clk1);
                if (RD) DataIn <= mem[Addr];
                if (WR) mem[Addr] <= DataOut;
            end
        join_none
        for (int i = 0; i < 65536; i++) put(16'(i), 16'h0000);

        reset_start();
        put(0, ri(4'h6, 3'd1, 9'h0FF));
        put(1, ri(4'h7, 3'd1, 9'h07F));
        put(2, ri(4'h6, 3'd2, 9'h001));
        put(3, rr(4'h0, 3'd3, 3'd1, 3'd2));
        put(4, rr(4'h1, 3'd4, 3'd3, 3'd3));
        put(5, ri(4'h6, 3'd5, 9'h040));
        put(6, ri(4'h3, 3'd3, {3'd5, 6'd2}));
        put(7, ri(4'h4, 3'd6, {3'd5, 6'd2}));
        put(8, 16'hF000);
        put(9, 16'hF123);
        put(10, ri(4'h9, 3'd4, 9'd3));
        for (int i = 11; i < 14; i++) put(16'(i), ri(4'h6, 3'd7, 9'h0AA));
        put(14, ri(4'h9, 3'd3, 9'd3));
        put(15, 16'h5A5A);
        put(16, {4'h8, 12'd1});
        put(17, ri(4'h6, 3'd7, 9'h0AA));
        put(18, ri(4'h3, 3'd6, {3'd0, 6'h10}));
        put(19, 16'hE000);
        release_reset();
        run_prog(100, h);
        chk("directed_halted", {15'd0, h}, 16'd1);
        chk("sst_mem", mem[16'h0042], 16'h8000);
        chk("sld_reg_dump", mem[16'h0010], 16'h8000);
        dump_chk();

        reset_start();
        put(0, {4'h8, 12'hFFE});
        put(16'hFFFF, ri(4'h6, 3'd1, 9'h012));
        release_reset();
        repeat (6) run_instr(h);
        reset_start();
        put(0, {4'h8, 12'hFFF});
        release_reset();
        repeat (4) run_instr(h);

        for (int p = 0; p < 8; p++) begin
            reset_start();
            for (int i = 0; i < 40; i++) put(16'(i), rnd_ins());
            for (int i = 40; i < 48; i++) put(16'(i), 16'hE000);
            release_reset();
            run_prog(400, h);
            dump_chk();
        end

        reset_start();
        put(0, ri(4'h6, 3'd1, 9'h0FF));
        put(1, ri(4'h7, 3'd1, 9'h07F));
        put(2, ri(4'h6, 3'd2, 9'h001));
        put(3, rr(4'h0, 3'd3, 3'd1, 3'd2));
        put(4, ri(4'h6, 3'd5, 9'h040));
        put(5, ri(4'h3, 3'd5, {3'd5, 6'd1}));
        put(6, 16'hE000);
        release_reset();
        repeat (5) run_instr(h);
        chk("v_before_reset", {15'd0, V}, 16'd1);
        @(negedge Clk1);
        @(negedge Clk1);
        @(negedge Clk1);
        chk("sst_strobe", {15'd0, WR}, 16'd1);
        #1 reset_start();
        @(posedge Clk1);
        #1 chk("aborted_write", mem[16'h0041], mm[16'h0041]);
        Reset = 1'b1;
        run_prog(50, h);
        chk("rerun_halted", {15'd0, h}, 16'd1);
        dump_chk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
